// File: rtl/clock_div_stepdown.sv
// -----------------------------------------------------------------------------
// clock_div_stepdown
//
// Integer clock divider. It derives a slow clock from clk_i, and it has a
// runtime step-down mode that doubles the division ratio.
//
// The high phase is floor(Deff/2) cycles and the low phase is ceil(Deff/2)
// cycles. As a result, an odd divisor gives a low-biased duty cycle.
//
// The step-down request is sampled only at the period boundary, which is the
// edge where the divided clock rises. The new ratio therefore always starts
// from a full, fresh phase.
//
// Ports:
//   clk_i            source clock; all state updates on its rising edge
//   rst_i            asynchronous, active-high reset
//   step_down_req_i  level request to divide by 2*Divisor
//   step_down_ack_o  high while the 2*Divisor ratio is in effect
//   test_en_i        bypass; when 1, clk_o follows clk_i
//   clk_o            divided clock, or clk_i in bypass
//
// Handshake: req is level-sensitive and is sampled only at the 0->1 edge of
// the divided clock. ack is a registered copy of the sampled req and changes
// only on that same edge, so there is no combinational path from req to ack.
// -----------------------------------------------------------------------------
module clock_div_stepdown #(
  parameter int   Divisor    = 2,
  parameter logic ResetValue = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic step_down_req_i,
  output logic step_down_ack_o,
  input  logic test_en_i,
  output logic clk_o
);

  // The counter must hold Divisor-1, which is the longest phase in step-down mode.
  localparam int CW = (Divisor < 2) ? 1 : $clog2(2 * Divisor);

  // Terminal count for each phase. In step-down mode Deff is even, so both
  // phases are Divisor cycles long.
  localparam logic [CW-1:0] HI_LAST_N = CW'(Divisor / 2 - 1);
  localparam logic [CW-1:0] LO_LAST_N = CW'(Divisor - Divisor / 2 - 1);
  localparam logic [CW-1:0] LAST_S    = CW'(Divisor - 1);

  if (Divisor < 2) begin : g_bad_divisor
    $error("clock_div_stepdown: Divisor must be >= 2");
  end

  logic          clk_div;
  logic [CW-1:0] cnt;
  logic          step_active;
  logic [CW-1:0] phase_last;

  always_comb begin
    phase_last = LO_LAST_N;
    if (step_active) begin
      phase_last = LAST_S;
    end else if (clk_div) begin
      phase_last = HI_LAST_N;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_div     <= ResetValue;
      cnt         <= '0;
      step_active <= 1'b0;
    end else if (cnt == phase_last) begin
      clk_div <= ~clk_div;
      cnt     <= '0;
      // On a rising toggle, a new period begins, so the mode can change here.
      if (!clk_div) begin
        step_active <= step_down_req_i;
      end
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign step_down_ack_o = step_active;

  // This is a plain mux. The bypass is a test feature and does not need a
  // glitch-free switch.
  assign clk_o = test_en_i ? clk_i : clk_div;

endmodule

// File: tb/tb_clock_div_stepdown.sv
module tb_clock_div_stepdown;

  logic clk = 1'b0;
  logic rst;
  logic req;
  logic ten;
  logic clk_o_a, ack_a;
  logic clk_o_b, ack_b;

  int checks   = 0;
  int failures = 0;

  // Each entry holds {ack, divided level}.
  logic [1:0] exp_q_a[$];
  logic [1:0] exp_q_b[$];

  // clock / reset
  always #5 clk = ~clk;

  clock_div_stepdown #(.Divisor(4), .ResetValue(1'b0)) u_dut_a (
    .clk_i           (clk),
    .rst_i           (rst),
    .step_down_req_i (req),
    .step_down_ack_o (ack_a),
    .test_en_i       (ten),
    .clk_o           (clk_o_a)
  );

  clock_div_stepdown #(.Divisor(3), .ResetValue(1'b1)) u_dut_b (
    .clk_i           (clk),
    .rst_i           (rst),
    .step_down_req_i (req),
    .step_down_ack_o (ack_b),
    .test_en_i       (ten),
    .clk_o           (clk_o_b)
  );

  // Reference model. It tracks the position inside the current period, where
  // position 0 is the rising boundary. The level is high for the first
  // floor(Deff/2) positions of the period.
  typedef struct {
    int d;
    int pos;
    int deff;
    bit act;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset(int d, bit rv);
    mdl_t m;
    m.d    = d;
    m.deff = d;
    m.act  = 1'b0;
    // A low start means the bench is at the beginning of the low part of a period.
    m.pos  = rv ? 0 : d / 2;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit r);
    m.pos = m.pos + 1;
    if (m.pos == m.deff) begin
      m.pos  = 0;
      m.act  = r;
      m.deff = r ? 2 * m.d : m.d;
    end
    return m;
  endfunction

  function automatic logic lvl(mdl_t m);
    return (m.pos < m.deff / 2);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      ma = mdl_reset(4, 1'b0);
      mb = mdl_reset(3, 1'b1);
    end else begin
      ma = mdl_step(ma, req);
      mb = mdl_step(mb, req);
    end
    exp_q_a.push_back({ma.act, lvl(ma)});
    exp_q_b.push_back({mb.act, lvl(mb)});
  end

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor: the bench samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    logic [1:0] e;
    if (exp_q_a.size() > 0) begin
      e = exp_q_a.pop_front();
      chk("clk_o_a", clk_o_a, ten ? 1'b0 : e[0]);
      chk("ack_a", ack_a, e[1]);
    end
    if (exp_q_b.size() > 0) begin
      e = exp_q_b.pop_front();
      chk("clk_o_b", clk_o_b, ten ? 1'b0 : e[0]);
      chk("ack_b", ack_b, e[1]);
    end
  end

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    req = 1'b0;
    ten = 1'b0;
    #1;
    chk("reset_clk_o_a", clk_o_a, 1'b0);
    chk("reset_clk_o_b", clk_o_b, 1'b1);
    chk("reset_ack_a", ack_a, 1'b0);
    cyc(3);
    rst = 1'b0;
    cyc(20);

    // Request step-down in the middle of a high phase of instance a.
    for (int i = 0; i < 8 && !lvl(ma); i++) cyc(1);
    req = 1'b1;
    cyc(12);
    chk("ack_a_raised", ack_a, 1'b1);
    cyc(28);
    req = 1'b0;
    cyc(12);
    chk("ack_a_dropped", ack_a, 1'b0);
    cyc(18);

    // Short request pulses that avoid the boundary edge of instance a.
    for (int i = 0; i < 6; i++) begin
      cyc($urandom_range(3, 9));
      if (ma.pos != ma.deff - 1) begin
        req = 1'b1;
        cyc(1);
        req = 1'b0;
      end
    end
    cyc(1);
    chk("ack_a_pulse_ignored", ack_a, 1'b0);
    cyc(10);

    // Random request and bypass activity.
    for (int i = 0; i < 14; i++) begin
      req = 1'($urandom_range(0, 1));
      ten = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(1, 20));
    end
    req = 1'b0;
    ten = 1'b0;
    cyc(20);

    // Bypass: clk_o must follow clk_i, so it is high just after the rising edge.
    ten = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      chk("bypass_hi_a", clk_o_a, 1'b1);
      chk("bypass_hi_b", clk_o_b, 1'b1);
    end
    @(negedge clk);
    #2;
    ten = 1'b0;
    cyc(20);

    // Asynchronous reset in the middle of a phase while in step-down mode.
    req = 1'b1;
    cyc(30);
    chk("pre_reset_ack_a", ack_a, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    chk("async_clk_o_a", clk_o_a, 1'b0);
    chk("async_ack_a", ack_a, 1'b0);
    chk("async_clk_o_b", clk_o_b, 1'b1);
    chk("async_ack_b", ack_b, 1'b0);
    cyc(2);
    req = 1'b0;
    rst = 1'b0;
    cyc(24);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
